// File: rtl/synchro_pkg.sv
// Shared constants and the count-vector type for the synchro counter.
// SYNCHRO_GRAY_EN (in synchro.sv) selects a registered Gray-coded output.
package synchro_pkg;

    localparam int SYNCHRO_W       = 4;
    localparam int SYNCHRO_MOD_DEF = 16;

    typedef logic [SYNCHRO_W-1:0] synchro_cnt_t;

    function automatic synchro_cnt_t synchro_gray(synchro_cnt_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/synchro_tff.sv
// Single toggle cell with synchronous active-high reset.
module synchro_tff (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/synchro.sv
// Free-running synchronous modulo-MODULUS counter built from toggle cells.
// Define SYNCHRO_GRAY_EN to register a Gray-coded copy of the count onto q.
module synchro
    import synchro_pkg::*;
#(
    parameter int MODULUS = SYNCHRO_MOD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] q
);

    if ((MODULUS < 2) || (MODULUS > 16)) begin : g_bad_modulus
        $error("synchro: MODULUS must be within 2..16");
    end

    localparam logic         LP_TRUNC = (MODULUS != SYNCHRO_MOD_DEF);
    localparam synchro_cnt_t LP_TC    = synchro_cnt_t'(MODULUS - 1);

    synchro_cnt_t w_cnt;
    synchro_cnt_t w_carry;
    synchro_cnt_t w_t;
    logic         w_tc;

    always_comb begin
        logic v_acc;
        v_acc   = 1'b1;
        w_carry = '0;
        for (int i = 0; i < SYNCHRO_W; i++) begin
            w_carry[i] = v_acc;
            v_acc      = v_acc & w_cnt[i];
        end
        // Terminal or illegal count: toggle exactly the set bits so all clear.
        w_tc = LP_TRUNC && (w_cnt >= LP_TC);
        w_t  = w_tc ? w_cnt : w_carry;
    end

    for (genvar g = 0; g < SYNCHRO_W; g++) begin : g_cell
        synchro_tff u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (w_t[g]),
            .q     (w_cnt[g])
        );
    end

`ifdef SYNCHRO_GRAY_EN
    synchro_cnt_t w_next;
    synchro_cnt_t r_gray;

    assign w_next = w_cnt ^ w_t;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gray <= '0;
        end else begin
            r_gray <= synchro_gray(w_next);
        end
    end

    assign q = r_gray;
`else
    assign q = w_cnt;
`endif

endmodule

// File: tb/tb_synchro.sv
// Randomized self-checking bench for synchro (MODULUS 16 and 10 instances).
module tb_synchro;

    logic       clk;
    logic       reset;
    logic [3:0] q16;
    logic [3:0] q10;

    int errors = 0;
    int checks = 0;

    synchro #(.MODULUS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q16)
    );

    synchro #(.MODULUS(10)) dut10 (
        .clk   (clk),
        .reset (reset),
        .q     (q10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] enc(int v);
        logic [3:0] b;
        b = v[3:0];
`ifdef SYNCHRO_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    int   m16 = 0;
    int   m10 = 0;
    logic mvalid = 1'b0;
    logic mrst_last = 1'b1;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m16       <= 0;
            m10       <= 0;
            mvalid    <= 1'b1;
            mrst_last <= 1'b1;
        end else if (mvalid) begin
            m16       <= (m16 + 1) % 16;
            m10       <= (m10 + 1) % 10;
            mrst_last <= 1'b0;
        end
    end

    logic [3:0] prev16;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_q16", q16, enc(m16));
            chk("model_q10", q10, enc(m10));
`ifdef SYNCHRO_GRAY_EN
            if (!mrst_last) begin
                checks++;
                if ($countones(q16 ^ prev16) != 1) begin
                    errors++;
                    $display("FAIL gray_onebit: got %b from %b expected one-bit change",
                             q16, prev16);
                end
            end
`endif
            prev16 = q16;
        end
    end

    task automatic edge_step(logic rst);
        @(negedge clk);
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    int exp16[20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10,
                      11, 12, 13, 14, 15, 0, 1, 2, 3, 4};
    int exp10[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
`ifdef SYNCHRO_GRAY_EN
    logic [3:0] gray_lit[4] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
`endif

    initial begin
        logic [3:0] hold16;
        logic [3:0] hold10;
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            edge_step(1'b1);
            chk("rst_hold16", q16, 4'b0000);
            chk("rst_hold10", q10, 4'b0000);
        end
        for (int i = 1; i <= 3; i++) begin
            edge_step(1'b0);
            chk("rst_release", q16, enc(i));
        end

        edge_step(1'b1);
        for (int i = 0; i < 20; i++) begin
            edge_step(1'b0);
`ifdef SYNCHRO_GRAY_EN
            if (i < 4) chk("gray_literal", q16, gray_lit[i]);
`endif
            chk("full_cycle16", q16, enc(exp16[i]));
            if (i < 11) chk("trunc_cycle10", q10, enc(exp10[i]));
        end

        edge_step(1'b1);
        for (int i = 0; i < 7; i++) edge_step(1'b0);
        chk("mid_at7", q16, enc(7));
        edge_step(1'b1);
        chk("mid_reset", q16, 4'b0000);
        edge_step(1'b0);
        chk("mid_after", q16, enc(1));

        for (int i = 0; i < 4; i++) edge_step(1'b0);
        @(negedge clk);
        hold16 = q16;
        hold10 = q10;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("glitch_q16", q16, hold16);
        chk("glitch_q10", q10, hold10);
        @(posedge clk);
        #1;
        chk("glitch_next", q16, enc(6));

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            reset = ($urandom_range(0, 31) == 0);
            @(posedge clk);
        end
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/synchro.md
SYNCHRO -- requirements
Module: synchro

Interface
REQ-001 The block SHALL have parameter MODULUS, default 16, giving the count cycle length; legal range 2..16.
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 Port q SHALL be: q  output  4  current counter value, driven directly from registers.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset; it SHALL have no other inputs (free-running).

Function
REQ-006 The block SHALL be a 4-bit synchronous up-counter: all state bits share clk and change on the same edge (no ripple clocking).
REQ-007 Each state bit i SHALL be a toggle cell whose toggle enable is the AND of state bits 0..i-1 (bit 0 enable tied to 1), modified by REQ-009.
REQ-008 When not in reset and count < MODULUS-1, the internal count SHALL increment by 1 on each rising edge (latency 1 cycle).
REQ-009 When count == MODULUS-1, the next count SHALL be 0; toggle enables SHALL be forced so all set bits clear on that edge.
REQ-010 For MODULUS=16, wrap SHALL occur naturally from 15 to 0 with no terminal-count logic active.
REQ-011 Count values >= MODULUS SHALL be unreachable after reset; if reached (e.g. X-propagation, SEU), the next count SHALL be 0.
REQ-012 Without SYNCHRO_GRAY_EN, q SHALL equal the internal binary count.
REQ-013 The MODULUS check SHALL be static: a value outside 2..16 SHALL cause an elaboration-time error.

Reset
REQ-014 When reset is 1 at a rising clk edge, internal count SHALL become 0 and q SHALL become 4'b0000 on that edge.
REQ-015 Reset SHALL take priority over counting and wrap; asserting it mid-cycle SHALL have no effect until the next rising edge.
REQ-016 After reset deasserts, the first counting edge SHALL produce count 1.
REQ-017 Before the first reset, q SHALL be undefined; no initial-value reliance is permitted.

Configuration
REQ-018 Macro SYNCHRO_GRAY_EN: when defined, q SHALL be the Gray code of the internal count (q = count XOR (count >> 1)), registered so q changes on the same edge as count.
REQ-019 When SYNCHRO_GRAY_EN is defined, reset value of q SHALL remain 4'b0000; wrap from MODULUS-1 to 0 is only single-bit when MODULUS is a power of two.
REQ-020 When SYNCHRO_GRAY_EN is undefined, no Gray logic SHALL be present and REQ-012 SHALL apply.

Structure
REQ-021 Package synchro_pkg SHALL hold constant SYNCHRO_W = 4, default modulus constant SYNCHRO_MOD_DEF = 16, and the count-vector typedef synchro_cnt_t (SYNCHRO_W bits).
REQ-022 Sub-module synchro_tff SHALL implement one toggle cell (inputs clk, reset, t; output q; synchronous active-high reset to 0); synchro SHALL instantiate SYNCHRO_W of them with the carry/terminal-count logic outside.

Verification
REQ-023 Reset: hold reset=1 for 3 edges -> q == 0 after each edge; release -> q == 1,2,3 on following edges.
REQ-024 Full cycle, MODULUS=16, binary: 20 edges after reset -> q sequence 1..15, 0, 1, 2, 3, 4.
REQ-025 Truncated cycle, MODULUS=10: after reset, edges -> 1..9, 0, 1; value 10..15 never appears.
REQ-026 Mid-count reset: at q=7 assert reset for 1 edge -> q == 0; next edge q == 1.
REQ-027 SYNCHRO_GRAY_EN defined, MODULUS=16: after reset, edges -> q = 0001, 0011, 0010, 0110, ...; every transition including 1000 -> 0000 changes exactly one bit.
REQ-028 Synchronicity check: toggle reset between clock edges without an edge occurring -> q unchanged.
